// File: rtl/cordic_pkg.sv
// Shared constants and FSM encoding for the CORDIC arcsine feeder.
package cordic_pkg;

    localparam int unsigned Q_FRAC    = 12;
    localparam logic [15:0] Q_ONE     = 16'h1000;
    localparam logic [15:0] Q_NEG_ONE = 16'hF000;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrop,
        StOut
    } state_t;

endpackage

// File: rtl/cordic_arcsine_feeder_if.sv
// Stream-in, core handshake and stream-out signals of the arcsine feeder.
interface cordic_arcsine_feeder_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 16
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 core_start;
    logic [WIDTH-1:0]     core_z;
    logic [WIDTH-1:0]     core_result;
    logic                 core_done;
    logic                 core_error;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_err;
    logic                 out_timeout;
    logic [CNT_WIDTH-1:0] sample_cnt;
    logic [CNT_WIDTH-1:0] err_cnt;

    // Environment side: upstream producer, the core itself and the downstream sink.
    modport master (
        output in_valid, in_data, core_result, core_done, core_error, out_ready,
        input  in_ready, core_start, core_z, out_valid, out_data, out_err, out_timeout,
        input  sample_cnt, err_cnt
    );

    // Feeder side.
    modport slave (
        input  in_valid, in_data, core_result, core_done, core_error, out_ready,
        output in_ready, core_start, core_z, out_valid, out_data, out_err, out_timeout,
        output sample_cnt, err_cnt
    );

endinterface

// File: rtl/cordic_sample_fifo.sv
// Synchronous FIFO buffering input samples; extra pointer MSB tells full from empty.
module cordic_sample_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign pop_data = mem[rd_ptr_q[AW-1:0]];

    // Pointer advance; reset flushes by equalising the pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop && !empty) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cordic_arcsine_feeder.sv
// Stream front-end for the CORDIC arcsine core: buffers samples, runs the core
// one sample at a time with a completion watchdog, and returns results in order.
module cordic_arcsine_feeder
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 32,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    cordic_arcsine_feeder_if.slave  bus
);

    localparam int unsigned WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0]      WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0]      WD_ONE  = WD_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_q;
    logic [WIDTH-1:0]     z_hold_q;
    logic                 start_q;
    logic [WD_W-1:0]      watchdog_q;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_data_q;
    logic                 out_err_q;
    logic                 out_timeout_q;
    logic [CNT_WIDTH-1:0] sample_cnt_q;
    logic [CNT_WIDTH-1:0] err_cnt_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_data;

    // Pop only from registered empty, so a freshly pushed sample waits one cycle.
    assign fifo_pop = (state_q == StIdle) && !fifo_empty;

    cordic_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.in_valid),
        .push_data (bus.in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.in_ready    = !fifo_full;
    assign bus.core_start  = start_q;
    assign bus.core_z      = z_hold_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_err     = out_err_q;
    assign bus.out_timeout = out_timeout_q;
    assign bus.sample_cnt  = sample_cnt_q;
    assign bus.err_cnt     = err_cnt_q;

    // Sequencer: IDLE -> RUN (core busy) -> DROP (start low) -> OUT (hold result).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            z_hold_q      <= '0;
            start_q       <= 1'b0;
            watchdog_q    <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_err_q     <= 1'b0;
            out_timeout_q <= 1'b0;
            sample_cnt_q  <= '0;
            err_cnt_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        z_hold_q   <= fifo_data;
                        watchdog_q <= '0;
                        start_q    <= 1'b1;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    watchdog_q <= watchdog_q + WD_ONE;
                    // Error outranks done when the core raises both.
                    if (bus.core_error) begin
                        out_data_q    <= '0;
                        out_err_q     <= 1'b1;
                        out_timeout_q <= 1'b0;
                        start_q       <= 1'b0;
                        state_q       <= StDrop;
                    end else if (bus.core_done) begin
                        out_data_q    <= bus.core_result;
                        out_err_q     <= 1'b0;
                        out_timeout_q <= 1'b0;
                        start_q       <= 1'b0;
                        state_q       <= StDrop;
                    end else if (watchdog_q == WD_LAST) begin
                        out_data_q    <= '0;
                        out_err_q     <= 1'b1;
                        out_timeout_q <= 1'b1;
                        start_q       <= 1'b0;
                        state_q       <= StDrop;
                    end
                end
                StDrop: begin
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (!(&sample_cnt_q)) sample_cnt_q <= sample_cnt_q + CNT_ONE;
                        if (out_err_q && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + CNT_ONE;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
